ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, meaning RAM address width.
REQ-002 SHALL have parameter DW, default 16, meaning RAM data width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports a_req, a_we, input, 1 bit each: requester A access request and write enable.
REQ-006 SHALL have ports a_addr (input, AW) and a_wdata (input, DW): requester A address and write data.
REQ-007 SHALL have ports a_gnt, a_rvalid (output, 1 bit each) and a_rdata (output, DW): A grant, read-valid strobe and read data.
REQ-008 SHALL have ports b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: the same widths and meanings as the A ports, for requester B.
REQ-009 SHALL have ports ram_we (output, 1), ram_addr (output, AW) and ram_din (output, DW): drive the single-port 256x16 RAM.
REQ-010 SHALL have port ram_dout, input, DW: RAM read data, valid one clk after the address is presented.
REQ-011 SHALL have port wait_cnt, output, 8 bits: saturating count of cycles a requester was denied.

Function
REQ-012 SHALL grant at most one requester per cycle; x_gnt is combinational from the current x_req and the priority state, and is high only in the cycle the access is issued.
REQ-013 SHALL drive ram_addr and ram_din from the granted requester in the grant cycle, and ram_we = granted x_we.
REQ-014 SHALL, with no grant, drive ram_we = 0 and hold ram_addr and ram_din at their last granted values.
REQ-015 SHALL arbitrate round-robin.
  - Single requester: that requester wins.
  - Both requesting: the requester not granted most recently wins.
  - The last-granted pointer updates only on a grant.
REQ-016 SHALL allow back-to-back grants every cycle, to the same or alternating requesters, with no idle cycles.
REQ-017 SHALL treat a read grant (x_we = 0) as follows: the next cycle, x_rvalid = 1 for exactly one cycle and x_rdata = ram_dout.
  - Read latency is exactly 1 clk from grant to rvalid.
  - Only the owner of the read sees rvalid.
REQ-018 SHALL generate no rvalid for a write grant.
REQ-019 SHALL hold x_rdata at its last valid value while x_rvalid = 0.
REQ-020 SHALL handle a write followed by a read of the same address in the next grant with RAM semantics only: read data is whatever the RAM returns, with no forwarding.
REQ-021 SHALL require a requester to keep x_req, x_we, x_addr and x_wdata stable until x_gnt; a request deasserted before grant is dropped with no side effect.
REQ-022 SHALL increment wait_cnt by 1 in each cycle where a_req = 1 and b_req = 1 (one requester denied), saturating at 255 with no wrap.
REQ-023 SHALL let a simultaneous read response for one requester and a new grant to the other proceed in the same cycle independently.

Reset
REQ-024 SHALL, while reset_n = 0, immediately force the following values regardless of clk:
  - a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we = 0
  - ram_addr, ram_din, a_rdata, b_rdata = 0
  - wait_cnt = 0
  - last-granted pointer = B, so A wins the first tie
REQ-025 SHALL discard any read in flight when reset asserts; no rvalid follows reset release.
REQ-026 SHALL accept requests in the first rising clk edge after reset_n deasserts.

Verification
REQ-027 Single read: after reset, a_req = 1, a_we = 0, a_addr = 0x10, RAM[0x10] = 0xBEEF.
  - Required: a_gnt = 1 in cycle 0, ram_addr = 0x10, ram_we = 0.
  - Required: a_rvalid = 1 and a_rdata = 0xBEEF in cycle 1, then a_rvalid = 0.
REQ-028 Tie after reset: a_req = b_req = 1 held for 4 cycles.
  - Required grant order: A, B, A, B.
  - Required: wait_cnt = 4 at the end.
REQ-029 Write then read: B writes 0x1234 to 0x05, then B reads 0x05.
  - Required: ram_we = 1 only in the write grant cycle.
  - Required: b_rvalid = 1 with b_rdata = 0x1234 one cycle after the read grant; a_rvalid stays 0 throughout.
REQ-030 Saturation: both requesters held for 300 cycles -> wait_cnt = 255, with no wrap.
REQ-031 Reset during read: assert reset_n = 0 in the cycle after a read grant.
  - Required: a_rvalid = 0 immediately and all outputs at reset values.
  - Required: no rvalid after release.
REQ-032 Mixed back-to-back: A read 0x01 in cycle 0, B write 0x02 in cycle 1.
  - Required in cycle 1: a_rvalid = 1 together with b_gnt = 1 and ram_we = 1.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Grants are combinational; read data returns one clock after a read grant.
module ram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [7:0]    wait_cnt
);

  logic          r_last_b;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;
  logic          r_a_rvalid;
  logic          r_b_rvalid;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;
  logic [7:0]    r_wait_cnt;
  logic          w_a_win;

  // Grant selection and RAM port steering; reset masks every grant.
  always_comb begin
    w_a_win  = a_req & (~b_req | r_last_b);
    a_gnt    = reset_n & w_a_win;
    b_gnt    = reset_n & b_req & ~w_a_win;
    ram_we   = 1'b0;
    ram_addr = r_addr;
    ram_din  = r_din;
    if (a_gnt) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_din  = a_wdata;
    end else if (b_gnt) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_wdata;
    end else begin
      ram_we   = 1'b0;
    end
  end

  // Read data passes RAM output through during rvalid, otherwise holds the last value.
  always_comb begin
    a_rdata = r_a_rdata;
    b_rdata = r_b_rdata;
    if (r_a_rvalid) begin
      a_rdata = ram_dout;
    end else begin
      a_rdata = r_a_rdata;
    end
    if (r_b_rvalid) begin
      b_rdata = ram_dout;
    end else begin
      b_rdata = r_b_rdata;
    end
  end

  // Priority pointer, held RAM address/data, read tracking and wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_b   <= 1'b1;
      r_addr     <= {AW{1'b0}};
      r_din      <= {DW{1'b0}};
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= {DW{1'b0}};
      r_b_rdata  <= {DW{1'b0}};
      r_wait_cnt <= 8'd0;
    end else begin
      if (a_gnt || b_gnt) begin
        r_last_b <= b_gnt;
        r_addr   <= ram_addr;
        r_din    <= ram_din;
      end
      r_a_rvalid <= a_gnt & ~a_we;
      r_b_rvalid <= b_gnt & ~b_we;
      if (r_a_rvalid) r_a_rdata <= ram_dout;
      if (r_b_rvalid) r_b_rdata <= ram_dout;
      // Saturate rather than wrap so long contention stays visible.
      if (a_req && b_req && (r_wait_cnt != 8'hFF)) r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign wait_cnt = r_wait_cnt;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural 256x16 RAM and
// per-requester read-data scoreboards.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [7:0]  a_addr = 8'd0, b_addr = 8'd0;
  logic [15:0] a_wdata = 16'd0, b_wdata = 16'd0;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;
  logic [15:0] a_rdata, b_rdata, ram_din;
  logic [15:0] ram_dout = 16'd0;
  logic [7:0]  ram_addr, wait_cnt;

  logic [15:0] mem [256];
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int checks = 0;
  int errors = 0;

  ram_arbiter #(.AW(8), .DW(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous read-first RAM
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Scoreboard: every rvalid must match the oldest expected read for that requester
  always @(negedge clk) begin
    if (a_rvalid) begin
      checks++;
      if (qa.size() == 0) begin
        errors++; $display("FAIL sb_a: unexpected a_rvalid, rdata=%h", a_rdata);
      end else begin
        logic [15:0] e;
        e = qa.pop_front();
        if (a_rdata !== e) begin errors++; $display("FAIL sb_a: got %h expected %h", a_rdata, e); end
      end
    end
    if (b_rvalid) begin
      checks++;
      if (qb.size() == 0) begin
        errors++; $display("FAIL sb_b: unexpected b_rvalid, rdata=%h", b_rdata);
      end else begin
        logic [15:0] e;
        e = qb.pop_front();
        if (b_rdata !== e) begin errors++; $display("FAIL sb_b: got %h expected %h", b_rdata, e); end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    step(); step();
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    a_req = 1'b1; b_req = 1'b1; a_addr = 8'h33; b_addr = 8'h44;
    #3;
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we} !== 5'b0 || ram_addr !== 8'h00 ||
        ram_din !== 16'h0000 || a_rdata !== 16'h0000 || b_rdata !== 16'h0000 || wait_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_vals: gnt=%b%b rv=%b%b we=%b addr=%h din=%h rd=%h/%h wc=%0d required all zero",
               a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, ram_addr, ram_din, a_rdata, b_rdata, wait_cnt);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    step();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    qa.push_back(16'hBEEF);
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || ram_addr !== 8'h10 || ram_we !== 1'b0) begin
      errors++; $display("FAIL single_grant: gnt=%b%b addr=%h we=%b required 10 10 0", a_gnt, b_gnt, ram_addr, ram_we);
    end
    step(); a_req = 1'b0;
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL single_rvalid: rvalid=%b rdata=%h required 1 beef", a_rvalid, a_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL single_hold: rvalid=%b rdata=%h required 0 beef", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_tie();
    do_reset();
    step();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 16'hA0A0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h21; b_wdata = 16'hB0B0;
    for (int i = 0; i < 4; i++) begin
      logic ea;
      ea = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (a_gnt !== ea || b_gnt !== !ea || ram_we !== 1'b1 ||
          ram_din !== (ea ? 16'hA0A0 : 16'hB0B0)) begin
        errors++; $display("FAIL tie_order[%0d]: gnt=%b%b din=%h required a=%b", i, a_gnt, b_gnt, ram_din, ea);
      end
      step();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (wait_cnt !== 8'd4) begin errors++; $display("FAIL tie_wait: wait_cnt=%0d required 4", wait_cnt); end
  endtask

  task automatic test_write_read();
    do_reset();
    step();
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h05; b_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if (b_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h05 || ram_din !== 16'h1234) begin
      errors++; $display("FAIL wr_grant: gnt=%b we=%b addr=%h din=%h required 1 1 05 1234", b_gnt, ram_we, ram_addr, ram_din);
    end
    step();
    b_we = 1'b0;
    qb.push_back(16'h1234);
    @(negedge clk);
    checks++;
    if (b_gnt !== 1'b1 || ram_we !== 1'b0 || b_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_grant: gnt=%b we=%b rvalid=%b required 1 0 0", b_gnt, ram_we, b_rvalid);
    end
    step(); idle_inputs();
    @(negedge clk);
    checks++;
    if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0 || ram_we !== 1'b0) begin
      errors++; $display("FAIL rd_resp: b_rvalid=%b a_rvalid=%b we=%b required 1 0 0", b_rvalid, a_rvalid, ram_we);
    end
    step();
    @(negedge clk);
    checks++;
    if (b_rvalid !== 1'b0 || b_rdata !== 16'h1234) begin
      errors++; $display("FAIL rd_after: rvalid=%b rdata=%h required 0 1234", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
    qa.push_back(16'h5A01);
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1) begin errors++; $display("FAIL mixed_c0: a_gnt=%b required 1", a_gnt); end
    step();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h02; b_wdata = 16'hCAFE;
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || b_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h02) begin
      errors++; $display("FAIL mixed_c1: a_rvalid=%b b_gnt=%b we=%b addr=%h required 1 1 1 02", a_rvalid, b_gnt, ram_we, ram_addr);
    end
    step(); idle_inputs();
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 8'h02 || ram_din !== 16'hCAFE || b_rvalid !== 1'b0) begin
      errors++; $display("FAIL idle_hold: we=%b addr=%h din=%h b_rvalid=%b required 0 02 cafe 0", ram_we, ram_addr, ram_din, b_rvalid);
    end
  endtask

  task automatic test_drop();
    do_reset();
    step();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h30; a_wdata = 16'h1111;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h31;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL drop_c0: gnt=%b%b required 10", a_gnt, b_gnt); end
    step(); idle_inputs();
    @(negedge clk);
    checks++;
    if (b_gnt !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 8'h30) begin
      errors++; $display("FAIL drop_c1: b_gnt=%b we=%b addr=%h required 0 0 30", b_gnt, ram_we, ram_addr);
    end
    step(); step();
  endtask

  task automatic test_saturation();
    do_reset();
    step();
    a_req = 1'b1; a_we = 1'b1; b_req = 1'b1; b_we = 1'b1;
    for (int i = 0; i < 300; i++) step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (wait_cnt !== 8'd255) begin errors++; $display("FAIL saturate: wait_cnt=%0d required 255", wait_cnt); end
  endtask

  task automatic test_reset_during_read();
    do_reset();
    step();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (a_rvalid !== 1'b0 || a_gnt !== 1'b0 || a_rdata !== 16'h0000 || ram_addr !== 8'h00 || wait_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_read: rvalid=%b gnt=%b rdata=%h addr=%h wc=%0d required all zero", a_rvalid, a_gnt, a_rdata, ram_addr, wait_cnt);
    end
    a_req = 1'b0;
    step();
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
        errors++; $display("FAIL rst_release[%0d]: rvalid=%b%b required 00", i, a_rvalid, b_rvalid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 | 16'(i);
    mem[8'h10] = 16'hBEEF;
    test_reset();
    test_single_read();
    test_tie();
    test_write_read();
    test_back_to_back();
    test_drop();
    test_saturation();
    test_reset_during_read();
    step();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++; $display("FAIL sb_drain: pending a=%0d b=%0d required 0 0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
